pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Multicycle fetch/PC controller that owns the architectural PC register.
- Sequences one instruction at a time: fetch from instruction memory, issue to execute, wait for resolution, then commit the next PC.
- Drives the select inputs of the PC adder (PCAsrc/PCBsrc) and latches its 32-bit next_pc result.
- Detects instruction-memory timeout and misaligned targets.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- MAX_WAIT, 8, max cycles in FETCH without imem_ready before fault (range 1..255).

Ports:
- clk  in  1  system clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address, always equals pc.
- imem_ready  in  1  rdata valid this cycle.
- imem_rdata  in  32  fetched instruction.
- instr  out  32  latched instruction to execute.
- instr_valid  out  1  instr offered to execute.
- ex_ready  in  1  execute accepts instr.
- ex_done  in  1  execute resolved control flow (single-cycle pulse).
- br_taken  in  1  branch/jal taken (qualified by ex_done).
- is_jalr  in  1  jalr (qualified by ex_done).
- pc_a_src  out  1  PCAsrc to adder: 1 = imm offset, 0 = +4.
- pc_b_src  out  1  PCBsrc to adder: 1 = Ra base, 0 = pc base.
- next_pc  in  32  adder result, combinational from pc/Ra/imm and the two selects.
- pc  out  32  architectural PC.
- retired  out  32  count of committed instructions.
- fault  out  1  sticky fault flag.
- fault_cause  out  2  00 none, 01 fetch timeout, 10 misaligned target.

Behaviour:
- Reset (rstn low, async):
  - State BOOT; pc=RESET_PC; all other outputs 0 (instr=0, retired=0, fault=0, fault_cause=00); wait counter cleared.
  - Reset asserted in any state aborts the operation immediately; no partial commit.
- States:
  - BOOT: exactly one cycle after rstn rises, then FETCH.
  - FETCH: imem_req=1, imem_addr=pc; wait counter increments each cycle.
    - imem_ready=1: instr<=imem_rdata, go ISSUE.
    - imem_ready=0 when counter==MAX_WAIT-1: go FAULT, cause 01.
    - Counter clears on entry to FETCH.
  - ISSUE: instr_valid=1, instr stable. ex_ready=1 completes the handshake; go EXEC. instr_valid holds until then.
  - EXEC: instr_valid=0. Wait for ex_done; ex_done in any other state is ignored.
    - On ex_done: pc_a_src=br_taken|is_jalr; pc_b_src=is_jalr (is_jalr implies a_src=1 regardless of br_taken).
    - Selects are registered into UPDATE and held stable there; they read 0 in every other state.
  - UPDATE (1 cycle): adder output is valid.
    - next_pc[1:0]!=0: pc unchanged, go FAULT, cause 10.
    - Otherwise: pc<=next_pc, retired<=retired+1 (wraps 2^32-1 -> 0), go FETCH.
  - FAULT: terminal until reset. fault=1, imem_req=0, instr_valid=0, pc frozen, inputs ignored.
- Latency: best case (imem_ready and ex_ready in first cycle, ex_done first EXEC cycle) is 4 cycles per instruction (FETCH, ISSUE, EXEC, UPDATE).
- PC arithmetic is modulo 2^32: pc=FFFF_FFFC with +4 commits 0000_0000 without fault.
- Simultaneous events:
  - imem_ready on the same cycle the timeout would trigger: ready wins.
  - ex_ready and ex_done both high in ISSUE: ex_done ignored; execute must pulse ex_done in EXEC.
- pc changes only in UPDATE (and reset). imem_addr equals pc at all times.

Test Plan:
- Reset release, RESET_PC=0x100, imem_ready on first FETCH cycle, ex_ready/ex_done immediate, no branch -> imem_addr=0x100, pc=0x104 four cycles later, retired=1, selects (0,0) in UPDATE.
- Taken branch: ex_done with br_taken=1, adder returns 0x80 -> pc_a_src=1, pc_b_src=0 in UPDATE; pc=0x80 and next fetch addr=0x80.
- jalr: is_jalr=1 with br_taken=0, next_pc=0x2001 -> selects (1,1); FAULT, cause 10, pc unchanged, imem_req stays 0 afterward.
- Timeout: MAX_WAIT=8, imem_ready held 0 -> fault=1, cause 01 after 8 FETCH cycles. Variant with imem_ready on cycle 8 -> no fault, enters ISSUE.
- Backpressure: ex_ready low 5 cycles -> instr_valid and instr held stable; ex_done pulsed during ISSUE is ignored; later ex_done in EXEC commits pc+4.
- Async reset mid-EXEC and mid-FAULT -> outputs zero and pc=RESET_PC immediately without waiting for a clock edge; retired cleared; normal fetch resumes after one BOOT cycle.

Source files
------------

// File: rtl/pc_sequencer_if.sv
// Fetch/execute/PC-adder signal bundle between the PC sequencer and its
// surroundings. The master side is the sequencer. The slave side is the
// instruction memory, the execute stage and the PC adder.
interface pc_sequencer_if;
    // Instruction memory
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    // Execute handshake and control-flow resolution
    logic [31:0] instr;
    logic        instr_valid;
    logic        ex_ready;
    logic        ex_done;
    logic        br_taken;
    logic        is_jalr;
    // PC adder
    logic        pc_a_src;
    logic        pc_b_src;
    logic [31:0] next_pc;
    // Architectural state and status
    logic [31:0] pc;
    logic [31:0] retired;
    logic        fault;
    logic [1:0]  fault_cause;

    modport master (
        output imem_req, imem_addr, instr, instr_valid,
               pc_a_src, pc_b_src, pc, retired, fault, fault_cause,
        input  imem_ready, imem_rdata, ex_ready, ex_done,
               br_taken, is_jalr, next_pc
    );

    modport slave (
        input  imem_req, imem_addr, instr, instr_valid,
               pc_a_src, pc_b_src, pc, retired, fault, fault_cause,
        output imem_ready, imem_rdata, ex_ready, ex_done,
               br_taken, is_jalr, next_pc
    );
endinterface

// File: rtl/pc_sequencer.sv
// Multicycle fetch/PC controller. It owns the architectural PC and runs one
// instruction at a time through FETCH -> ISSUE -> EXEC -> UPDATE. It steers
// the external PC adder and commits the adder result. An instruction-memory
// timeout or a misaligned target parks the block in a sticky FAULT state.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned MAX_WAIT = 8
) (
    input  logic          clk,
    input  logic          rstn,
    pc_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        S_BOOT,
        S_FETCH,
        S_ISSUE,
        S_EXEC,
        S_UPDATE,
        S_FAULT
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    localparam logic [1:0] CAUSE_TIMEOUT    = 2'b01;
    localparam logic [1:0] CAUSE_MISALIGNED = 2'b10;

    state_t      r_state;
    state_t      w_next_state;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_retired;
    logic [7:0]  r_wait_cnt;
    logic        r_a_src;
    logic        r_b_src;
    logic [1:0]  r_fault_cause;

    logic        w_timeout;
    logic        w_misaligned;

    // The last allowed FETCH cycle has passed with no data. If imem_ready
    // arrives on that same cycle, the fetch still completes.
    assign w_timeout    = (r_state == S_FETCH) && !bus.imem_ready && (r_wait_cnt == WAIT_LAST);
    assign w_misaligned = (bus.next_pc[1:0] != 2'b00);

    // State register.
    // NOTE: sequential state uses non-blocking assignments, so every flop
    // samples the pre-edge values and the assignment order does not matter.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= S_BOOT;
        else       r_state <= w_next_state;
    end

    // Next-state logic for the fetch/issue/execute/update sequence.
    always_comb begin
        // NOTE: the default assignment first means every path assigns
        // w_next_state, so no latch is inferred.
        w_next_state = r_state;
        case (r_state)
            S_BOOT:   w_next_state = S_FETCH;
            S_FETCH: begin
                if (bus.imem_ready) w_next_state = S_ISSUE;
                else if (w_timeout) w_next_state = S_FAULT;
            end
            S_ISSUE:  if (bus.ex_ready) w_next_state = S_EXEC;
            S_EXEC:   if (bus.ex_done)  w_next_state = S_UPDATE;
            S_UPDATE: w_next_state = w_misaligned ? S_FAULT : S_FETCH;
            S_FAULT:  w_next_state = S_FAULT;
            default:  w_next_state = S_FAULT;
        endcase
    end

    // Datapath: wait counter, instruction latch, adder selects, PC commit, fault cause.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_pc          <= RESET_PC;
            r_instr       <= '0;
            r_retired     <= '0;
            r_wait_cnt    <= '0;
            r_a_src       <= 1'b0;
            r_b_src       <= 1'b0;
            r_fault_cause <= 2'b00;
        end else begin
            // The counter runs only in FETCH. It reads zero on every FETCH entry.
            r_wait_cnt <= (r_state == S_FETCH) ? r_wait_cnt + 8'd1 : 8'd0;

            if (r_state == S_FETCH && bus.imem_ready)
                r_instr <= bus.imem_rdata;

            // The selects are loaded on the EXEC->UPDATE edge and cleared one
            // cycle later. This makes them nonzero only during UPDATE.
            if (r_state == S_EXEC && bus.ex_done) begin
                r_a_src <= bus.br_taken | bus.is_jalr;
                r_b_src <= bus.is_jalr;
            end else begin
                r_a_src <= 1'b0;
                r_b_src <= 1'b0;
            end

            if (r_state == S_UPDATE) begin
                if (w_misaligned) begin
                    r_fault_cause <= CAUSE_MISALIGNED;
                end else begin
                    r_pc      <= bus.next_pc;
                    r_retired <= r_retired + 32'd1;
                end
            end

            if (w_timeout)
                r_fault_cause <= CAUSE_TIMEOUT;
        end
    end

    assign bus.imem_req    = (r_state == S_FETCH);
    assign bus.imem_addr   = r_pc;
    assign bus.instr       = r_instr;
    assign bus.instr_valid = (r_state == S_ISSUE);
    assign bus.pc_a_src    = r_a_src;
    assign bus.pc_b_src    = r_b_src;
    assign bus.pc          = r_pc;
    assign bus.retired     = r_retired;
    assign bus.fault       = (r_state == S_FAULT);
    assign bus.fault_cause = r_fault_cause;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer. It covers straight-line commits, a taken
// branch, jalr, PC wrap, backpressure, a misaligned target, the fetch
// timeout, and async reset in EXEC and FAULT. A small PC adder model
// supplies next_pc.
module tb_pc_sequencer;

    logic        clk;
    logic        rstn;
    logic [31:0] ra;
    logic [31:0] imm;
    int          n_cmp;
    int          n_bad;

    pc_sequencer_if bus ();

    pc_sequencer #(
        .RESET_PC (32'h0000_0100),
        .MAX_WAIT (8)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    // PC adder: base is Ra or pc, and the offset is imm or 4.
    assign bus.next_pc = (bus.pc_b_src ? ra : bus.pc) + (bus.pc_a_src ? imm : 32'd4);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Mid-cycle async reset. It checks the reset values before any clock
    // edge, then releases at a falling edge and checks the BOOT cycle.
    // The task returns at the first FETCH cycle.
    task automatic async_reset(input string tag);
        #2 rstn = 1'b0;
        #1;
        check({tag, "_pc"},      bus.pc,          32'h100);
        check({tag, "_addr"},    bus.imem_addr,   32'h100);
        check({tag, "_retired"}, bus.retired,     32'd0);
        check({tag, "_fault"},   bus.fault,       1'b0);
        check({tag, "_cause"},   bus.fault_cause, 2'b00);
        check({tag, "_instr"},   bus.instr,       32'd0);
        check({tag, "_req"},     bus.imem_req,    1'b0);
        check({tag, "_valid"},   bus.instr_valid, 1'b0);
        @(negedge clk);
        rstn = 1'b1;
        #1 check({tag, "_boot_req"}, bus.imem_req, 1'b0);
        @(negedge clk);
        check({tag, "_fetch_req"}, bus.imem_req, 1'b1);
    endtask

    // Runs one instruction, starting at a falling edge in FETCH. The task
    // holds ex_ready low for `stall` ISSUE cycles and pulses a stray
    // ex_done during ISSUE when stalled. It checks the selects in UPDATE
    // against exp_a/exp_b and returns at the falling edge after UPDATE.
    task automatic do_instr(input string tag, input logic [31:0] word,
                            input logic bt, input logic jr,
                            input logic [31:0] ra_v, input logic [31:0] imm_v,
                            input int stall, input logic exp_a, input logic exp_b);
        check({tag, "_req"}, bus.imem_req, 1'b1);
        bus.imem_ready = 1'b1;
        bus.imem_rdata = word;
        @(negedge clk);
        bus.imem_ready = 1'b0;
        bus.imem_rdata = 32'hDEAD_BEEF;
        check({tag, "_valid"}, bus.instr_valid, 1'b1);
        check({tag, "_instr"}, bus.instr, word);
        for (int i = 0; i < stall; i++) begin
            bus.ex_done  = (i == 1);
            bus.br_taken = (i == 1);
            @(negedge clk);
            bus.ex_done  = 1'b0;
            bus.br_taken = 1'b0;
            check({tag, "_hold_valid"}, bus.instr_valid, 1'b1);
            check({tag, "_hold_instr"}, bus.instr, word);
        end
        bus.ex_ready = 1'b1;
        // A stalled run also raises ex_done alongside ex_ready. ISSUE must
        // ignore it.
        bus.ex_done  = (stall > 0);
        bus.br_taken = (stall > 0);
        @(negedge clk);
        bus.ex_ready = 1'b0;
        bus.ex_done  = 1'b0;
        bus.br_taken = 1'b0;
        check({tag, "_exec_valid"}, bus.instr_valid, 1'b0);
        if (stall > 0) begin
            @(negedge clk);
            check({tag, "_exec_wait_a"}, bus.pc_a_src, 1'b0);
            check({tag, "_exec_wait_req"}, bus.imem_req, 1'b0);
        end
        ra           = ra_v;
        imm          = imm_v;
        bus.ex_done  = 1'b1;
        bus.br_taken = bt;
        bus.is_jalr  = jr;
        @(negedge clk);
        bus.ex_done  = 1'b0;
        bus.br_taken = 1'b0;
        bus.is_jalr  = 1'b0;
        check({tag, "_a_src"}, bus.pc_a_src, exp_a);
        check({tag, "_b_src"}, bus.pc_b_src, exp_b);
        @(negedge clk);
        check({tag, "_a_after"}, bus.pc_a_src, 1'b0);
        check({tag, "_b_after"}, bus.pc_b_src, 1'b0);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rstn  = 1'b0;
        ra    = '0;
        imm   = '0;
        bus.imem_ready = 1'b0;
        bus.imem_rdata = '0;
        bus.ex_ready   = 1'b0;
        bus.ex_done    = 1'b0;
        bus.br_taken   = 1'b0;
        bus.is_jalr    = 1'b0;

        @(negedge clk);
        @(negedge clk);
        check("rst_pc",      bus.pc,          32'h100);
        check("rst_retired", bus.retired,     32'd0);
        check("rst_fault",   bus.fault,       1'b0);
        check("rst_cause",   bus.fault_cause, 2'b00);
        check("rst_instr",   bus.instr,       32'd0);
        check("rst_req",     bus.imem_req,    1'b0);
        rstn = 1'b1;
        #1 check("boot_req", bus.imem_req, 1'b0);
        @(negedge clk);

        // Plain instruction: 0x100 -> 0x104 four cycles after the fetch.
        check("i1_addr", bus.imem_addr, 32'h100);
        do_instr("i1", 32'h0000_0013, 1'b0, 1'b0, 32'h0, 32'h0, 0, 1'b0, 1'b0);
        check("i1_pc",      bus.pc,        32'h104);
        check("i1_addr2",   bus.imem_addr, 32'h104);
        check("i1_retired", bus.retired,   32'd1);

        // Taken branch to 0x80: imm = 0x80 - 0x104.
        do_instr("i2", 32'h1111_1111, 1'b1, 1'b0, 32'h0, 32'hFFFF_FF7C, 0, 1'b1, 1'b0);
        check("i2_pc",      bus.pc,        32'h80);
        check("i2_addr",    bus.imem_addr, 32'h80);
        check("i2_retired", bus.retired,   32'd2);

        // Backpressure: ex_ready held low for five cycles, with stray ex_done pulses.
        do_instr("i3", 32'h2222_2222, 1'b0, 1'b0, 32'h0, 32'h0, 5, 1'b0, 1'b0);
        check("i3_pc",      bus.pc,      32'h84);
        check("i3_retired", bus.retired, 32'd3);

        // jalr with br_taken also high, to FFFF_FFFC.
        do_instr("i4", 32'h3333_3333, 1'b1, 1'b1, 32'hFFFF_FFFC, 32'h0, 0, 1'b1, 1'b1);
        check("i4_pc",      bus.pc,      32'hFFFF_FFFC);
        check("i4_retired", bus.retired, 32'd4);

        // The +4 step wraps the PC to zero without a fault.
        do_instr("i5", 32'h4444_4444, 1'b0, 1'b0, 32'h0, 32'h0, 0, 1'b0, 1'b0);
        check("i5_pc",      bus.pc,      32'h0);
        check("i5_retired", bus.retired, 32'd5);
        check("i5_fault",   bus.fault,   1'b0);

        // jalr to 0x2001 is misaligned, so the block faults and keeps the PC.
        do_instr("i6", 32'h5555_5555, 1'b0, 1'b1, 32'h2000, 32'h1, 0, 1'b1, 1'b1);
        check("i6_fault",   bus.fault,       1'b1);
        check("i6_cause",   bus.fault_cause, 2'b10);
        check("i6_pc",      bus.pc,          32'h0);
        check("i6_retired", bus.retired,     32'd5);
        bus.imem_ready = 1'b1;
        bus.ex_ready   = 1'b1;
        bus.ex_done    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("flt_req",   bus.imem_req,    1'b0);
            check("flt_valid", bus.instr_valid, 1'b0);
            check("flt_pc",    bus.pc,          32'h0);
            check("flt_fault", bus.fault,       1'b1);
        end
        bus.imem_ready = 1'b0;
        bus.ex_ready   = 1'b0;
        bus.ex_done    = 1'b0;

        // Async reset while in FAULT.
        async_reset("rst_flt");

        // Timeout: no imem_ready for 8 FETCH cycles.
        for (int i = 1; i < 8; i++) begin
            @(negedge clk);
            check("to_wait_fault", bus.fault, 1'b0);
            check("to_wait_req",   bus.imem_req, 1'b1);
        end
        @(negedge clk);
        check("to_fault", bus.fault,       1'b1);
        check("to_cause", bus.fault_cause, 2'b01);
        check("to_req",   bus.imem_req,    1'b0);
        check("to_pc",    bus.pc,          32'h100);

        // imem_ready arrives on the 8th FETCH cycle: no fault, go to ISSUE.
        async_reset("rst_to");
        for (int i = 1; i < 8; i++) @(negedge clk);
        bus.imem_ready = 1'b1;
        bus.imem_rdata = 32'h6666_6666;
        @(negedge clk);
        bus.imem_ready = 1'b0;
        check("late_fault", bus.fault,       1'b0);
        check("late_valid", bus.instr_valid, 1'b1);
        check("late_instr", bus.instr,       32'h6666_6666);

        // Move into EXEC, then reset in the middle of the cycle.
        bus.ex_ready = 1'b1;
        @(negedge clk);
        bus.ex_ready = 1'b0;
        check("mid_exec_valid", bus.instr_valid, 1'b0);
        async_reset("rst_exec");

        // Normal fetch resumes from RESET_PC.
        check("resume_addr", bus.imem_addr, 32'h100);
        do_instr("r1", 32'h7777_7777, 1'b0, 1'b0, 32'h0, 32'h0, 0, 1'b0, 1'b0);
        check("r1_pc",      bus.pc,      32'h104);
        check("r1_retired", bus.retired, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
